// File: rtl/sr_chk_pkg.sv
// Shared types and encodings for the SR flip-flop checker.
// Error codes are bit-packed: bit0 = q mismatch, bit1 = complement violation.
package sr_chk_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'b00,
    UNSYNC = 2'b01,
    HALT   = 2'b10
  } chk_state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_Q    = 2'b01;
  localparam logic [1:0] ERR_CMP  = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;

  // s/r request encodings, packed as {s, r}
  localparam logic [1:0] SR_HOLD = 2'b00;
  localparam logic [1:0] SR_RST  = 2'b01;
  localparam logic [1:0] SR_SET  = 2'b10;
  localparam logic [1:0] SR_FORB = 2'b11;

  function automatic logic [1:0] buildCode(input logic qMis, input logic cmpViol);
    return (qMis ? ERR_Q : ERR_NONE) | (cmpViol ? ERR_CMP : ERR_NONE);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Sticks at all ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sr_ff_checker.sv
// Observer for a synchronous-reset SR flip-flop: tracks the expected q from the
// s/r stream and flags q mismatches and broken q/q_bar complements.
module sr_ff_checker
  import sr_chk_pkg::*;
#(
  parameter int   CNT_W       = 8,
  parameter logic RST_Q       = 1'b0,
  parameter bit   STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             q_bar,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] forb_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic             synced,
  output logic             halted
);

  chk_state_e state_q;
  logic       expQ_q;
  logic       err_q;
  logic [1:0] errCode_q;
  logic       synced_q;
  logic       halted_q;

  logic [1:0] srReq;
  logic       active;
  logic       qMis;
  logic       cmpViol;
  logic [1:0] code_d;
  logic       errDet;
  logic       chkInc;
  logic       forbInc;

  // q is checked against the model built from the previous edge's s/r
  always_comb begin
    srReq   = {s, r};
    active  = (state_q != HALT);
    qMis    = (state_q == SYNC) && (q != expQ_q);
    cmpViol = (q_bar == q);
    code_d  = buildCode(qMis, cmpViol);
    errDet  = active && en && ((code_d & ERR_BOTH) != ERR_NONE);
    chkInc  = active && en && (state_q == SYNC);
    forbInc = active && en && (srReq == SR_FORB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SYNC;
      expQ_q    <= RST_Q;
      err_q     <= 1'b0;
      errCode_q <= ERR_NONE;
      synced_q  <= 1'b1;
      halted_q  <= 1'b0;
    end else begin
      err_q <= errDet;
      if (errDet) begin
        errCode_q <= code_d;
      end
      // Halting freezes the model, so it wins over any s/r update this edge
      if (active) begin
        if (errDet && STOP_ON_ERR) begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end else begin
          case (srReq)
            SR_HOLD: begin
            end
            SR_RST, SR_SET: begin
              expQ_q   <= s;
              state_q  <= SYNC;
              synced_q <= 1'b1;
            end
            SR_FORB: begin
              state_q  <= UNSYNC;
              synced_q <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_errCnt (
    .clk (clk),
    .rst (rst),
    .inc (errDet),
    .cnt (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_forbCnt (
    .clk (clk),
    .rst (rst),
    .inc (forbInc),
    .cnt (forb_cnt)
  );

  sat_counter #(.W(CNT_W)) u_chkCnt (
    .clk (clk),
    .rst (rst),
    .inc (chkInc),
    .cnt (chk_cnt)
  );

  assign err      = err_q;
  assign err_code = errCode_q;
  assign synced   = synced_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_sr_ff_checker.sv
// Bench for sr_ff_checker: three instances (default, stop-on-error, 2-bit counters)
// share one s/r stream driven from a behavioural flip-flop with fault injection.
module tb_sr_ff_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic s = 1'b0;
  logic r = 1'b0;
  logic q = 1'b0;
  logic q_bar = 1'b1;

  logic       errA, syncedA, haltedA;
  logic [1:0] errCodeA;
  logic [7:0] errCntA, forbCntA, chkCntA;
  logic       errH, syncedH, haltedH;
  logic [1:0] errCodeH;
  logic [7:0] errCntH, forbCntH, chkCntH;
  logic       errS, syncedS, haltedS;
  logic [1:0] errCodeS;
  logic [1:0] errCntS, forbCntS, chkCntS;

  always #5 clk = ~clk;

  sr_ff_checker #(.CNT_W(8), .RST_Q(1'b0), .STOP_ON_ERR(1'b0)) dutA (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .q_bar(q_bar),
    .err(errA), .err_code(errCodeA), .err_cnt(errCntA), .forb_cnt(forbCntA),
    .chk_cnt(chkCntA), .synced(syncedA), .halted(haltedA)
  );

  sr_ff_checker #(.CNT_W(8), .RST_Q(1'b0), .STOP_ON_ERR(1'b1)) dutH (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .q_bar(q_bar),
    .err(errH), .err_code(errCodeH), .err_cnt(errCntH), .forb_cnt(forbCntH),
    .chk_cnt(chkCntH), .synced(syncedH), .halted(haltedH)
  );

  sr_ff_checker #(.CNT_W(2), .RST_Q(1'b0), .STOP_ON_ERR(1'b0)) dutS (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .q_bar(q_bar),
    .err(errS), .err_code(errCodeS), .err_cnt(errCntS), .forb_cnt(forbCntS),
    .chk_cnt(chkCntS), .synced(syncedS), .halted(haltedS)
  );

  typedef struct {
    bit       halted;
    bit       known;
    bit       expQ;
    bit       err;
    bit [1:0] code;
    int       errCnt;
    int       forbCnt;
    int       chkCnt;
    bit       synced;
  } model_t;

  typedef struct {
    bit       rst, en, s, r, injQ, injCmp;
    bit       expErr;
    bit [1:0] expCode;
    int       expErrCnt, expChkCnt, expForbCnt;
    bit       expSynced;
  } vec_t;

  model_t mA, mH, mS;
  bit     modelValid = 1'b0;
  bit     ffQ = 1'b0;
  int     testsRun = 0;
  int     failCount = 0;
  vec_t   vecs[24];

  function automatic int satInc(input int v, input int maxV);
    return (v < maxV) ? v + 1 : maxV;
  endfunction

  // Checker behaviour expressed as "is the model value known", not as FSM states
  function automatic model_t modelStep(input model_t m, input int cntMax, input bit stop,
                                       input bit iRst, input bit iEn, input bit iS,
                                       input bit iR, input bit iQ, input bit iQb);
    model_t n;
    bit     mis, cv;
    n = m;
    n.err = 1'b0;
    if (iRst) begin
      n = '{halted: 1'b0, known: 1'b1, expQ: 1'b0, err: 1'b0, code: 2'b00,
            errCnt: 0, forbCnt: 0, chkCnt: 0, synced: 1'b1};
      return n;
    end
    if (m.halted) return n;
    mis = m.known && (iQ != m.expQ);
    cv  = (iQb == iQ);
    if (iEn && m.known) n.chkCnt = satInc(m.chkCnt, cntMax);
    if (iEn && iS && iR) n.forbCnt = satInc(m.forbCnt, cntMax);
    if (iEn && (mis || cv)) begin
      n.err    = 1'b1;
      n.code   = {cv, mis};
      n.errCnt = satInc(m.errCnt, cntMax);
      if (stop) begin
        n.halted = 1'b1;
        return n;
      end
    end
    if (iS && iR) n.known = 1'b0;
    else if (iS != iR) begin
      n.known = 1'b1;
      n.expQ  = iS;
    end
    n.synced = n.known;
    return n;
  endfunction

  task automatic cmpVal(input string nm, input int act, input int expv);
    testsRun++;
    if (act != expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point
  task automatic applyStimulus(input bit iRst, input bit iEn, input bit iS, input bit iR,
                               input bit injQ, input bit injCmp);
    rst   = iRst;
    en    = iEn;
    s     = iS;
    r     = iR;
    q     = ffQ ^ injQ;
    q_bar = injCmp ? q : ~q;
    @(posedge clk);
    #1;
    mA = modelStep(mA, 255, 1'b0, iRst, iEn, iS, iR, q, q_bar);
    mH = modelStep(mH, 255, 1'b1, iRst, iEn, iS, iR, q, q_bar);
    mS = modelStep(mS, 3, 1'b0, iRst, iEn, iS, iR, q, q_bar);
    if (iRst) begin
      ffQ        = 1'b0;
      modelValid = 1'b1;
    end else if (iS != iR) begin
      ffQ = iS;
    end
  endtask

  task automatic checkOutput();
    if (modelValid) begin
      cmpVal("A.err", int'(errA), int'(mA.err));
      cmpVal("A.err_code", int'(errCodeA), int'(mA.code));
      cmpVal("A.err_cnt", int'(errCntA), mA.errCnt);
      cmpVal("A.forb_cnt", int'(forbCntA), mA.forbCnt);
      cmpVal("A.chk_cnt", int'(chkCntA), mA.chkCnt);
      cmpVal("A.synced", int'(syncedA), int'(mA.synced));
      cmpVal("A.halted", int'(haltedA), int'(mA.halted));
      cmpVal("H.err", int'(errH), int'(mH.err));
      cmpVal("H.err_code", int'(errCodeH), int'(mH.code));
      cmpVal("H.err_cnt", int'(errCntH), mH.errCnt);
      cmpVal("H.forb_cnt", int'(forbCntH), mH.forbCnt);
      cmpVal("H.chk_cnt", int'(chkCntH), mH.chkCnt);
      cmpVal("H.synced", int'(syncedH), int'(mH.synced));
      cmpVal("H.halted", int'(haltedH), int'(mH.halted));
      cmpVal("S.err", int'(errS), int'(mS.err));
      cmpVal("S.err_code", int'(errCodeS), int'(mS.code));
      cmpVal("S.err_cnt", int'(errCntS), mS.errCnt);
      cmpVal("S.forb_cnt", int'(forbCntS), mS.forbCnt);
      cmpVal("S.chk_cnt", int'(chkCntS), mS.chkCnt);
      cmpVal("S.synced", int'(syncedS), int'(mS.synced));
      cmpVal("S.halted", int'(haltedS), int'(mS.halted));
    end
  endtask

  initial begin
    // rst en s r injQ injCmp | err code errCnt chkCnt forbCnt synced (instance A)
    vecs[0]  = '{1,1,0,0,0,0, 0,2'b00,0,0,0,1};
    vecs[1]  = '{0,1,0,0,0,0, 0,2'b00,0,1,0,1};
    vecs[2]  = '{0,1,0,1,0,0, 0,2'b00,0,2,0,1};
    vecs[3]  = '{0,1,1,0,0,0, 0,2'b00,0,3,0,1};
    vecs[4]  = '{0,1,0,0,0,0, 0,2'b00,0,4,0,1};
    vecs[5]  = '{0,1,1,0,0,0, 0,2'b00,0,5,0,1};
    vecs[6]  = '{0,1,0,0,1,0, 1,2'b01,1,6,0,1};
    vecs[7]  = '{0,1,0,0,0,0, 0,2'b01,1,7,0,1};
    vecs[8]  = '{1,1,0,0,0,0, 0,2'b00,0,0,0,1};
    vecs[9]  = '{0,1,1,1,0,0, 0,2'b00,0,1,1,0};
    vecs[10] = '{0,1,0,0,0,1, 1,2'b10,1,1,1,0};
    vecs[11] = '{0,1,0,0,0,1, 1,2'b10,2,1,1,0};
    vecs[12] = '{0,1,0,0,0,0, 0,2'b10,2,1,1,0};
    vecs[13] = '{1,1,0,0,0,0, 0,2'b00,0,0,0,1};
    vecs[14] = '{0,1,1,1,0,0, 0,2'b00,0,1,1,0};
    vecs[15] = '{0,1,0,0,1,0, 0,2'b00,0,1,1,0};
    vecs[16] = '{0,1,0,0,1,0, 0,2'b00,0,1,1,0};
    vecs[17] = '{0,1,0,1,0,0, 0,2'b00,0,1,1,1};
    vecs[18] = '{0,1,0,0,0,0, 0,2'b00,0,2,1,1};
    vecs[19] = '{0,0,0,0,1,0, 0,2'b00,0,2,1,1};
    vecs[20] = '{0,0,1,1,0,0, 0,2'b00,0,2,1,0};
    vecs[21] = '{0,1,1,0,0,0, 0,2'b00,0,2,1,1};
    vecs[22] = '{0,1,1,1,1,0, 1,2'b01,1,3,2,0};
    vecs[23] = '{0,1,0,1,0,0, 0,2'b01,1,3,2,1};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].s, vecs[i].r, vecs[i].injQ, vecs[i].injCmp);
      checkOutput();
      cmpVal($sformatf("vec%0d.err", i), int'(errA), int'(vecs[i].expErr));
      cmpVal($sformatf("vec%0d.err_code", i), int'(errCodeA), int'(vecs[i].expCode));
      cmpVal($sformatf("vec%0d.err_cnt", i), int'(errCntA), vecs[i].expErrCnt);
      cmpVal($sformatf("vec%0d.chk_cnt", i), int'(chkCntA), vecs[i].expChkCnt);
      cmpVal($sformatf("vec%0d.forb_cnt", i), int'(forbCntA), vecs[i].expForbCnt);
      cmpVal($sformatf("vec%0d.synced", i), int'(syncedA), int'(vecs[i].expSynced));
    end

    // Stop-on-error: a further mismatch while halted must not be counted
    applyStimulus(1, 1, 0, 0, 0, 0); checkOutput();
    applyStimulus(0, 1, 1, 0, 0, 0); checkOutput();
    applyStimulus(0, 1, 0, 0, 1, 0); checkOutput();
    cmpVal("halt.entry.halted", int'(haltedH), 1);
    cmpVal("halt.entry.err", int'(errH), 1);
    cmpVal("halt.entry.err_cnt", int'(errCntH), 1);
    applyStimulus(0, 1, 0, 0, 1, 0); checkOutput();
    cmpVal("halt.held.halted", int'(haltedH), 1);
    cmpVal("halt.held.err", int'(errH), 0);
    cmpVal("halt.held.err_cnt", int'(errCntH), 1);
    applyStimulus(0, 1, 0, 1, 0, 0); checkOutput();
    cmpVal("halt.sticky.halted", int'(haltedH), 1);
    applyStimulus(1, 1, 0, 0, 0, 0); checkOutput();
    cmpVal("halt.rst.halted", int'(haltedH), 0);
    cmpVal("halt.rst.err_cnt", int'(errCntH), 0);
    cmpVal("halt.rst.chk_cnt", int'(chkCntH), 0);
    cmpVal("halt.rst.forb_cnt", int'(forbCntH), 0);

    // Two-bit counters: five errors, every one pulses err, count sticks at 3
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 0);
      checkOutput();
      cmpVal($sformatf("sat.err%0d", i), int'(errS), 1);
    end
    cmpVal("sat.err_cnt", int'(errCntS), 3);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(31) == 0), ($urandom_range(7) != 0),
                    ($urandom_range(1) == 1), ($urandom_range(1) == 1),
                    ($urandom_range(7) == 0), ($urandom_range(7) == 0));
      checkOutput();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
